ahb_decoder_np: RTL and testbench

Parametrised AHB-Lite decoder for one L1 bus-matrix input stage. It decodes the address-phase HADDR[31:10] against NUM_PORTS base/mask regions and drives one-hot output-stage selects. It multiplexes the data-phase response from the selected output stage. Unmapped or disabled regions are served by an embedded two-cycle ERROR default slave, which keeps a saturating error counter.

---
 rtl/ahb_decoder_np.sv | 132 +++++++++++++
 tb/tb_ahb_decoder_np.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_np.sv
// ahb_decoder_np: AHB-Lite address decoder for one bus-matrix input stage,
// with data-phase response mux and an embedded two-cycle ERROR default slave.
module ahb_decoder_np #(
    parameter int                      NUM_PORTS = 2,
    parameter logic [NUM_PORTS*22-1:0] PORT_BASE = {22'h080000, 22'h000000},
    parameter logic [NUM_PORTS*22-1:0] PORT_MASK = {22'h3FFFC0, 22'h3FFFC0}
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HREADYS,
    input  logic                   sel_dec,
    input  logic [21:0]            decode_addr_dec,
    input  logic [1:0]             trans_dec,
    input  logic [NUM_PORTS-1:0]   port_en,
    input  logic                   err_clr,
    input  logic [NUM_PORTS-1:0]   active_in,
    input  logic [NUM_PORTS-1:0]   readyout_in,
    input  logic [2*NUM_PORTS-1:0] resp_in,
    input  logic [32*NUM_PORTS-1:0] rdata_in,
    output logic [NUM_PORTS-1:0]   sel_out,
    output logic                   active_dec,
    output logic                   HREADYOUTS,
    output logic [1:0]             HRESPS,
    output logic [31:0]            HRDATAS,
    output logic [7:0]             err_count
);

    localparam int            DW  = $clog2(NUM_PORTS + 1);
    localparam logic [DW-1:0] DFT = DW'(NUM_PORTS);

    localparam logic [1:0] S_OKAY = 2'd0;
    localparam logic [1:0] S_ERR1 = 2'd1;
    localparam logic [1:0] S_ERR2 = 2'd2;

    logic [DW-1:0] r_data_port;
    logic [1:0]    r_state;
    logic [7:0]    r_err_count;

    logic [DW-1:0] w_match_idx;
    logic          w_match;
    logic [DW-1:0] w_addr_port;
    logic          w_dft_sel;
    logic          w_qual;
    logic          w_inc;
    logic [1:0]    w_state_nxt;
    logic          w_dft_ready;
    logic [1:0]    w_dft_resp;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = DFT;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (port_en[p] &&
                ((decode_addr_dec & PORT_MASK[22*p +: 22]) ==
                 PORT_BASE[22*p +: 22])) begin
                w_match     = 1'b1;
                w_match_idx = DW'(p);
            end
        end
    end

    // An unmapped IDLE keeps the current data port so idles cause no switch.
    always_comb begin
        if (w_match)
            w_addr_port = w_match_idx;
        else if (trans_dec == 2'b00)
            w_addr_port = r_data_port;
        else
            w_addr_port = DFT;
    end

    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_addr_port == DW'(p)) begin
                sel_out[p] = sel_dec;
                active_dec = active_in[p];
            end
        end
    end

    assign w_dft_sel = sel_dec & (w_addr_port == DFT);
    assign w_qual    = w_dft_sel & HREADYS & trans_dec[1];
    assign w_inc     = w_qual & (r_state != S_ERR1);

    always_comb begin
        w_state_nxt = S_OKAY;
        case (r_state)
            S_OKAY:  w_state_nxt = w_qual ? S_ERR1 : S_OKAY;
            S_ERR1:  w_state_nxt = S_ERR2;
            S_ERR2:  w_state_nxt = w_qual ? S_ERR1 : S_OKAY;
            default: w_state_nxt = S_OKAY;
        endcase
    end

    assign w_dft_ready = (r_state != S_ERR1);
    assign w_dft_resp  = (r_state == S_OKAY) ? 2'b00 : 2'b01;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_port <= DFT;
            r_state     <= S_OKAY;
            r_err_count <= 8'd0;
        end else begin
            if (HREADYS)
                r_data_port <= w_addr_port;
            r_state <= w_state_nxt;
            if (err_clr)
                r_err_count <= {7'd0, w_inc};
            else if (w_inc && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;

    always_comb begin
        HREADYOUTS = w_dft_ready;
        HRESPS     = w_dft_resp;
        HRDATAS    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_data_port == DW'(p)) begin
                HREADYOUTS = readyout_in[p];
                HRESPS     = resp_in[2*p +: 2];
                HRDATAS    = rdata_in[32*p +: 32];
            end
        end
    end

endmodule

// File: tb/tb_ahb_decoder_np.sv
// tb_ahb_decoder_np: randomized scoreboard bench for ahb_decoder_np against
// a transaction-level model of region decode, data phases and error counting.
module tb_ahb_decoder_np;

    localparam int NP  = 2;
    localparam int DFT = NP;

    logic        HCLK;
    logic        HRESETn;
    logic        HREADYS;
    logic        sel_dec;
    logic [21:0] decode_addr_dec;
    logic [1:0]  trans_dec;
    logic [1:0]  port_en;
    logic        err_clr;
    logic [1:0]  active_in;
    logic [1:0]  readyout_in;
    logic [3:0]  resp_in;
    logic [63:0] rdata_in;
    logic [1:0]  sel_out;
    logic        active_dec;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [7:0]  err_count;

    ahb_decoder_np dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .port_en         (port_en),
        .err_clr         (err_clr),
        .active_in       (active_in),
        .readyout_in     (readyout_in),
        .resp_in         (resp_in),
        .rdata_in        (rdata_in),
        .sel_out         (sel_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .err_count       (err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  sel;
        logic        act;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [7:0]  errc;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Memory map as byte ranges: two 64 KB windows.
    longint unsigned rbase [NP] = '{64'h0000_0000, 64'h2000_0000};
    longint unsigned rsize = 64'h1_0000;

    int          dp_port;
    int          dp_left;
    bit          dp_err;
    logic [31:0] dp_rdata;
    int          m_dport;
    int          m_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int region(input logic [31:0] a, input logic [1:0] en);
        longint unsigned ua = 64'(a);
        for (int p = 0; p < NP; p++)
            if (en[p] && ua >= rbase[p] && ua < rbase[p] + rsize)
                return p;
        return DFT;
    endfunction

    // One bus cycle, entered just after a rising edge.
    task automatic cycle(input logic [31:0] a, input logic [1:0] tr,
                         input logic s, input logic [1:0] en,
                         input logic clr);
        exp_t e;
        int   ap;
        bit   acc;
        bit   qual;
        decode_addr_dec = a[31:10];
        trans_dec       = tr;
        sel_dec         = s;
        port_en         = en;
        err_clr         = clr;
        active_in       = 2'($urandom);
        readyout_in     = 2'($urandom);
        resp_in         = 4'($urandom);
        rdata_in        = {$urandom, $urandom};
        if (dp_port == DFT) begin
            e.rdy   = !(dp_err && dp_left == 2);
            e.resp  = dp_err ? 2'b01 : 2'b00;
            e.rdata = 32'h0;
        end else begin
            e.rdy   = (dp_left == 1);
            e.resp  = 2'b00;
            e.rdata = dp_rdata;
            readyout_in[dp_port]      = e.rdy;
            resp_in[2*dp_port +: 2]   = 2'b00;
            rdata_in[32*dp_port +: 32] = dp_rdata;
        end
        acc     = e.rdy;
        HREADYS = acc;
        ap = region(a, en);
        if (ap == DFT && tr == 2'b00)
            ap = m_dport;
        e.sel  = (s && ap < NP) ? 2'(1 << ap) : 2'b00;
        e.act  = (ap == DFT) ? 1'b1 : active_in[ap];
        e.errc = 8'(m_err);
        q.push_back(e);
        qual = s && (ap == DFT) && acc && tr[1];
        if (clr)
            m_err = qual ? 1 : 0;
        else if (qual && m_err < 255)
            m_err++;
        if (acc) begin
            m_dport = ap;
            dp_port = ap;
            if (ap == DFT) begin
                dp_err  = s && tr[1];
                dp_left = dp_err ? 2 : 1;
            end else begin
                dp_err   = 1'b0;
                dp_left  = (s && tr[1]) ? 1 + $urandom_range(2, 0) : 1;
                dp_rdata = $urandom;
            end
        end else begin
            dp_left--;
        end
        @(posedge HCLK);
        #1;
    endtask

    // Holds the address until accepted; clr is applied on the accepting cycle.
    task automatic xfer(input logic [31:0] a, input logic [1:0] tr,
                        input logic s, input logic [1:0] en, input logic clr);
        int guard = 0;
        while (dp_left != 1 && guard < 8) begin
            cycle(a, tr, s, en, 1'b0);
            guard++;
        end
        cycle(a, tr, s, en, clr);
    endtask

    function automatic logic [31:0] raddr();
        case ($urandom_range(7, 0))
            0, 1:    return {16'h0000, 16'($urandom)};
            2, 3:    return {16'h2000, 16'($urandom)};
            4:       return {16'h4000, 16'($urandom)};
            5:       return 32'h0000_FFFC;
            6:       return 32'h2001_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [1:0] rtrans();
        case ($urandom_range(7, 0))
            0, 1:    return 2'b00;
            2:       return 2'b01;
            3, 4, 5: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always @(negedge HCLK) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sel_out",    32'(sel_out),    32'(e.sel));
                chk("active_dec", 32'(active_dec), 32'(e.act));
                chk("HREADYOUTS", 32'(HREADYOUTS), 32'(e.rdy));
                chk("HRESPS",     32'(HRESPS),     32'(e.resp));
                chk("HRDATAS",    HRDATAS,         e.rdata);
                chk("err_count",  32'(err_count),  32'(e.errc));
            end
        end
    end

    initial begin
        HRESETn         = 1'b0;
        HREADYS         = 1'b1;
        sel_dec         = 1'b0;
        decode_addr_dec = '0;
        trans_dec       = 2'b00;
        port_en         = 2'b11;
        err_clr         = 1'b0;
        active_in       = '0;
        readyout_in     = '1;
        resp_in         = '0;
        rdata_in        = '0;
        dp_port  = DFT;
        dp_left  = 1;
        dp_err   = 1'b0;
        dp_rdata = '0;
        m_dport  = DFT;
        m_err    = 0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        mon_en  = 1'b1;

        // Idle bus after reset.
        cycle(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        cycle(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        // Mapped read to port 0.
        xfer(32'h0000_1000, 2'b10, 1'b1, 2'b11, 1'b0);
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        // Port 1 disabled: falls through to the default slave.
        xfer(32'h2000_0000, 2'b10, 1'b1, 2'b01, 1'b0);
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        // Back-to-back unmapped transfers.
        xfer(32'h4000_0000, 2'b10, 1'b1, 2'b11, 1'b0);
        xfer(32'h4000_0000, 2'b10, 1'b1, 2'b11, 1'b0);
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        // IDLE to an unmapped address after a port-1 transfer.
        xfer(32'h2000_0040, 2'b10, 1'b1, 2'b11, 1'b0);
        xfer(32'h4000_0000, 2'b00, 1'b1, 2'b11, 1'b0);
        xfer(32'h4000_0000, 2'b00, 1'b1, 2'b11, 1'b0);
        // Saturation, then clear coinciding with an ERR1 entry.
        repeat (258) xfer(32'h4000_0000, 2'b10, 1'b1, 2'b11, 1'b0);
        xfer(32'h4000_0000, 2'b11, 1'b1, 2'b11, 1'b1);
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);

        repeat (1500)
            xfer(raddr(), rtrans(), ($urandom_range(7, 0) != 0),
                 ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b11,
                 ($urandom_range(63, 0) == 0));

        // Asynchronous reset in the middle of an ERROR wait state.
        xfer(32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
        xfer(32'h4000_0000, 2'b10, 1'b1, 2'b11, 1'b0);
        mon_en = 1'b0;
        chk("err1_before_reset", 32'(HREADYOUTS), 32'(dp_left != 2));
        sel_dec = 1'b0;
        #1;
        HRESETn = 1'b0;
        #1;
        chk("rst_HREADYOUTS", 32'(HREADYOUTS), 32'h1);
        chk("rst_HRESPS",     32'(HRESPS),     32'h0);
        chk("rst_HRDATAS",    HRDATAS,         32'h0);
        chk("rst_err_count",  32'(err_count),  32'h0);
        chk("rst_sel_out",    32'(sel_out),    32'h0);
        chk("rst_active_dec", 32'(active_dec), 32'h1);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
